// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 round sequencing constants and FSM encoding
package aes_pkg;

    localparam int AES_NR     = 10;
    localparam int AES_RIDX_W = 4;
    // MixColumns register depth; the round datapath uses the same value to stay in lockstep
    localparam int AES_MC_LAT = 1;

    typedef logic [AES_RIDX_W-1:0] ridx_t;
    typedef logic [1:0]            fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_ISSUE = 2'd1;
    localparam fsm_state_t ST_WAIT  = 2'd2;
    localparam fsm_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/aes_lat_timer.sv
// rtl/aes_lat_timer.sv - loadable down-counter with zero flag for the MixColumns wait
module aes_lat_timer #(
    parameter int MC_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    localparam int W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    if (MC_LAT < 1 || MC_LAT > 4) begin : g_bad_mc_lat
        $error("aes_lat_timer: MC_LAT must be 1..4");
    end

    logic [W-1:0] count;

    // Loaded on the issue cycle so the flag rises exactly MC_LAT cycles later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(MC_LAT - 1);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 round sequencer driving the shared round datapath
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR     = AES_NR,
    parameter int MC_LAT = AES_MC_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ld_state,
    output logic                  issue,
    output logic                  mc_bypass,
    output logic                  cap_state,
    output logic [AES_RIDX_W-1:0] round_idx,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  abort
);

    if (NR < 1 || NR > (1 << AES_RIDX_W) - 1) begin : g_bad_nr
        $error("aes_round_ctrl: NR must be 1..15");
    end

    localparam ridx_t LAST_IDX = ridx_t'(NR);

    fsm_state_t state;
    fsm_state_t state_nxt;
    ridx_t      ridx_nxt;
    logic       timer_zero;

    assign in_ready  = (state == ST_IDLE);
    assign ld_state  = in_valid & in_ready & ~abort;
    assign issue     = (state == ST_ISSUE);
    assign mc_bypass = issue && (round_idx == LAST_IDX);
    assign cap_state = (state == ST_WAIT) && timer_zero;
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);

    aes_lat_timer #(
        .MC_LAT (MC_LAT)
    ) u_lat_timer (
        .clk  (clk),
        .rst  (rst),
        .load (issue),
        .zero (timer_zero)
    );

    // abort wins over acceptance, round advance and result hand-off
    always_comb begin
        state_nxt = state;
        ridx_nxt  = round_idx;
        if (abort) begin
            state_nxt = ST_IDLE;
            ridx_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ld_state) begin
                        state_nxt = ST_ISSUE;
                        ridx_nxt  = ridx_t'(1);
                    end
                end
                ST_ISSUE: begin
                    state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (timer_zero) begin
                        if (round_idx == LAST_IDX) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_ISSUE;
                            ridx_nxt  = round_idx + ridx_t'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_nxt = ST_IDLE;
                        ridx_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    ridx_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            round_idx <= '0;
        end else begin
            state     <= state_nxt;
            round_idx <= ridx_nxt;
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - self-checking bench for aes_round_ctrl with a behavioural AES datapath
module tb_aes_round_ctrl;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, out_ready, abort;
    logic       in_ready, ld_state, issue, mc_bypass, cap_state, busy, out_valid;
    logic [3:0] round_idx;

    logic       in_valid3, out_ready3, abort3;
    logic       in_ready3, ld3, issue3, byp3, cap3, busy3, ov3;
    logic [3:0] ridx3;

    int tests = 0;
    int fails = 0;

    aes_round_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ld_state(ld_state), .issue(issue), .mc_bypass(mc_bypass),
        .cap_state(cap_state), .round_idx(round_idx), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .abort(abort)
    );

    aes_round_ctrl #(.NR(10), .MC_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .ld_state(ld3), .issue(issue3), .mc_bypass(byp3),
        .cap_state(cap3), .round_idx(ridx3), .busy(busy3),
        .out_valid(ov3), .out_ready(out_ready3), .abort(abort3)
    );

    // Behavioural AES round datapath (MixColumns register depth 1)
    logic [7:0]   sb [0:255];
    logic [127:0] rk [0:10];
    logic [127:0] mstate, pipe;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d = {b, b};
        d = d >> (8 - k);
        return d[7:0];
    endfunction

    function automatic logic [127:0] rnd(input logic [127:0] s, input logic byp);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = a[r + 4*((c + r) % 4)];
        if (!byp) begin
            for (int c = 0; c < 4; c++) begin
                a[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                a[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                a[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                a[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
            end
            for (int i = 0; i < 16; i++) t[i] = a[i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o;
    endfunction

    task automatic build_tables();
        logic [7:0]  p, rc;
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        for (int x = 0; x < 256; x++) begin
            p = 8'(x);
            for (int i = 1; i < 254; i++) p = gm(p, 8'(x));
            sb[x] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = KY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    always @(posedge clk) begin
        if (ld_state)       mstate <= PT ^ rk[0];
        else if (cap_state) mstate <= pipe ^ rk[round_idx];
        if (issue)          pipe   <= rnd(mstate, mc_bypass);
    end

    // Per-cycle vectors: inputs plus packed expected outputs
    typedef struct {
        logic        iv;
        logic        ordy;
        logic        ab;
        logic [10:0] exp;
    } vec_t;

    vec_t tab [0:127];
    int   nvec = 0;

    function automatic logic [10:0] pk(input logic isu, cap, byp, ov, ir, ld, bsy, input int ridx);
        return {isu, cap, byp, ov, ir, ld, bsy, 4'(ridx)};
    endfunction

    task automatic push(input logic iv, ordy, ab, isu, cap, byp, ov, ir, ld, bsy, input int ridx);
        tab[nvec] = '{iv, ordy, ab, pk(isu, cap, byp, ov, ir, ld, bsy, ridx)};
        nvec++;
    endtask

    // Cycles 1..last_c of a block with MC_LAT = 1: issue on odd, capture on even cycles
    task automatic push_rounds(input int last_c, input int abort_c);
        for (int c = 1; c <= last_c; c++) begin
            if (c % 2 == 1) push(0, 1, c == abort_c, 1, 0, c == 19, 0, 0, 0, 1, (c + 1) / 2);
            else            push(0, 1, c == abort_c, 0, 1, 0,       0, 0, 0, 1, c / 2);
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic range_check();
        assert (round_idx <= 4'd10 && ridx3 <= 4'd10)
        else begin
            fails++;
            $display("FAIL round_idx_range: got %0d/%0d, expected <= 10", round_idx, ridx3);
        end
    endtask

    function automatic logic [10:0] act_vec();
        return {issue, cap_state, mc_bypass, out_valid, in_ready, ld_state, busy, round_idx};
    endfunction

    initial begin
        int iss_n, cap_n, last_iss, ov_cyc, byp_n, byp_at;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0;
        in_valid3 = 1'b0; out_ready3 = 1'b1; abort3 = 1'b0;
        build_tables();

        // block 1: single pass, out_ready high
        push(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push_rounds(20, -1);
        push(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 10);
        push(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // block 2: 5 cycles of backpressure, in_valid ignored while DONE
        push(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push_rounds(20, -1);
        for (int k = 0; k < 5; k++) push(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 10);
        push(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 10);
        push(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // block 3: abort in round-4 capture cycle, immediate re-accept, abort priority
        push(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push_rounds(8, 8);
        push(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1);
        push(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        push(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        #1;
        check("reset_outputs", act_vec(), pk(0, 0, 0, 0, 1, 0, 0, 0));
        check("reset_outputs_mc3", {issue3, cap3, byp3, ov3, in_ready3, ld3, busy3, ridx3},
              pk(0, 0, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            in_valid  = tab[i].iv;
            out_ready = tab[i].ordy;
            abort     = tab[i].ab;
            #1;
            check($sformatf("vec%0d", i), act_vec(), tab[i].exp);
            if (tab[i].exp[7]) check($sformatf("ciphertext_vec%0d", i), mstate, CT);
            range_check();
        end

        // asynchronous reset in the middle of round 7
        @(negedge clk);
        in_valid = 1'b1; abort = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        #1 check("pre_rst_round7", act_vec(), pk(1, 0, 0, 0, 0, 0, 1, 7));
        #2 rst = 1'b1;
        #1 check("rst_async_drop", act_vec(), pk(0, 0, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("post_rst_idle%0d", k), act_vec(), pk(0, 0, 0, 0, 1, 0, 0, 0));
            @(negedge clk);
        end

        // MC_LAT = 3 instance
        iss_n = 0; cap_n = 0; last_iss = -100; ov_cyc = -1; byp_n = 0; byp_at = -1;
        in_valid3 = 1'b1;
        #1 check("mc3_accept", ld3, 1);
        @(negedge clk);
        in_valid3 = 1'b0;
        for (int c = 1; c < 60; c++) begin
            #1;
            range_check();
            if (issue3) begin
                iss_n++;
                last_iss = c;
                if (byp3) begin
                    byp_n++;
                    byp_at = iss_n;
                end
            end
            if (cap3) begin
                cap_n++;
                check($sformatf("mc3_cap%0d_gap", cap_n), c - last_iss, 3);
                check($sformatf("mc3_cap%0d_ridx", cap_n), ridx3, cap_n);
            end
            if (ov3 && ov_cyc < 0) ov_cyc = c;
            @(negedge clk);
        end
        check("mc3_issue_count", iss_n, 10);
        check("mc3_cap_count", cap_n, 10);
        check("mc3_out_valid_cycle", ov_cyc, 41);
        check("mc3_bypass_count", byp_n, 1);
        check("mc3_bypass_round", byp_at, 10);
        #1 check("mc3_back_idle", {in_ready3, ov3, busy3}, 3'b100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES-128 encryption sequencer. It drives the shared round datapath: the state register, SubBytes/ShiftRows, the registered MixColumns stage and AddRoundKey. It accepts one block per handshake, steps rounds 1..NR, bypasses MixColumns in the final round, and holds the result valid until the consumer takes it. It issues control only and carries no 128-bit data.

Parameters:
NR, 10, number of rounds (AES-128); legal 1..15
MC_LAT, 1, cycles from issue to round result at AddRoundKey input (MixColumns register depth); legal 1..4

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  plaintext/key presented by upstream
in_ready  output  1  controller can accept a block (state == IDLE)
ld_state  output  1  load state reg with plaintext XOR key0 this cycle
issue  output  1  feed state reg into round datapath this cycle
mc_bypass  output  1  round in flight is final: datapath skips MixColumns, same latency
cap_state  output  1  capture datapath output XOR roundkey[round_idx] into state reg
round_idx  output  4  current round number / round-key index (1..NR; 0 when idle)
busy  output  1  block in progress (ISSUE, WAIT or DONE)
out_valid  output  1  state reg holds ciphertext
out_ready  input  1  downstream accepts ciphertext
abort  input  1  synchronous cancel of the current block

Behaviour:
- Reset (async, any state, mid-block included): FSM = IDLE, round_idx = 0, wait count = 0. Outputs: issue, cap_state, mc_bypass, busy, out_valid = 0; in_ready = 1. No result is produced for a block interrupted by reset.
- in_ready and ld_state are combinational decodes: in_ready = (IDLE), ld_state = in_valid & in_ready & !abort. All other outputs are registered Moore decodes.
- IDLE: on ld_state, set round_idx to 1 and go to ISSUE.
- ISSUE (1 cycle): issue = 1; mc_bypass = (round_idx == NR). Load wait count with MC_LAT-1 and go to WAIT.
- WAIT: cap_state = 1 in exactly the cycle MC_LAT cycles after the issue cycle; wait count decrements before that cycle. In the cap cycle:
  - if round_idx == NR, go to DONE;
  - otherwise round_idx++ and go to ISSUE.
- DONE: out_valid = 1 and round_idx holds NR. On out_ready, go to IDLE next cycle. in_ready stays 0 in DONE, so a new block cannot be accepted in the out_ready cycle.
- Timing: per round 1+MC_LAT cycles. Latency from accept cycle to first out_valid cycle = 1 + NR*(1+MC_LAT); default 21.
- abort: any state, takes effect next edge. Go to IDLE, round_idx = 0, drop any pending result. abort has priority over in_valid, out_ready and round advance.
- out_valid stays stable and state reg stays unchanged while out_ready = 0. No backpressure limit.
- round_idx never wraps. Values above NR are unreachable; assert this in the bench.
- Width: round_idx is 4 bits, so NR ≤ 15 (elaboration check). MC_LAT outside 1..4 is an elaboration error.

Decomposition:
- Shared package aes_pkg:
  - AES_NR = 10
  - round index width = 4
  - FSM state encoding {IDLE, ISSUE, WAIT, DONE}
  - MixColumns pipeline depth constant = 1, which the datapath also uses to stay in lockstep
- One natural sub-module: aes_lat_timer. It is a loadable down-counter with a zero flag, parameterised by MC_LAT, used for the WAIT state. Everything else stays flat.

Test Plan:
- Reset then single block, out_ready = 1:
  - in_valid pulse at cycle 0 gives ld_state at cycle 0;
  - issue at cycles 1,3,…,19 and cap_state at cycles 2,4,…,20;
  - round_idx at the cap cycles = 1..10; mc_bypass only with the cycle-19 issue;
  - out_valid at cycle 21, for one cycle.
- Backpressure: out_ready = 0 for 5 cycles after out_valid.
  - out_valid is held for 6 cycles, in_ready = 0 throughout, no issue/cap;
  - IDLE follows the out_ready cycle.
- abort asserted in the cycle after the round-4 issue (the round-4 cap cycle):
  - FSM is IDLE next cycle, round_idx = 0, no out_valid;
  - a new in_valid is accepted the following cycle.
- rst asserted asynchronously mid-round 7 (between edges):
  - all registered outputs drop to 0 immediately;
  - after release in_ready = 1 and no stale out_valid.
- MC_LAT = 3 build: cap_state exactly 3 cycles after each issue; out_valid at cycle 1 + 10*4 = 41.
- Integration with datapath:
  - inputs: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f;
  - ciphertext at out_valid = 69c4e0d86a7b0430d8cdb78070b4c55a.
